// File: rtl/spectro_pkg.sv
// Shared constants, word indices and receiver state type for the spectrogram frame link.
package spectro_pkg;

    localparam int WORD_W    = 12;
    localparam int NUM_WORDS = 16;

    localparam logic [3:0] IDX_RTC  = 4'd0;
    localparam logic [3:0] IDX_CH1  = 4'd1;
    localparam logic [3:0] IDX_CH2  = 4'd2;
    localparam logic [3:0] IDX_CH3  = 4'd3;
    localparam logic [3:0] IDX_CH4  = 4'd4;
    localparam logic [3:0] IDX_CH5  = 4'd5;
    localparam logic [3:0] IDX_CH6  = 4'd6;
    localparam logic [3:0] IDX_CH7  = 4'd7;
    localparam logic [3:0] IDX_CH8  = 4'd8;
    localparam logic [3:0] IDX_CH9  = 4'd9;
    localparam logic [3:0] IDX_CH10 = 4'd10;
    localparam logic [3:0] IDX_CH11 = 4'd11;
    localparam logic [3:0] IDX_CH12 = 4'd12;
    localparam logic [3:0] IDX_CH13 = 4'd13;
    localparam logic [3:0] IDX_CH14 = 4'd14;
    localparam logic [3:0] IDX_CH15 = 4'd15;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

endpackage

// File: rtl/spectro_frame_rx_if.sv
// Serial link, word strobe and frame-buffer read signals of the frame receiver.
interface spectro_frame_rx_if #(
    parameter int WORD_W = 12
);
    logic              sdata;
    logic              frame_sync;
    logic [WORD_W-1:0] word_data;
    logic [3:0]        word_index;
    logic              word_valid;
    logic              frame_done;
    logic              frame_error;
    logic [3:0]        rd_addr;
    logic [WORD_W-1:0] rd_data;

    modport master (
        output sdata, frame_sync, rd_addr,
        input  word_data, word_index, word_valid, frame_done, frame_error, rd_data
    );

    modport slave (
        input  sdata, frame_sync, rd_addr,
        output word_data, word_index, word_valid, frame_done, frame_error, rd_data
    );
endinterface

// File: rtl/spectro_sipo.sv
// Serial-in/parallel-out word assembler; the parallel output already includes the bit on din.
module spectro_sipo #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] par
);
    // Only WIDTH-1 history bits are kept: the word is complete while its LSB is on din.
    logic [WIDTH-2:0] hist;

    always_ff @(posedge clk) begin
        if (clr) begin
            hist <= '0;
        end else if (shift_en) begin
            hist <= par[WIDTH-2:0];
        end
    end

    assign par = {hist, din};

endmodule

// File: rtl/spectro_frame_rx.sv
// Frame receiver: deserializes 16 x 12-bit words into a live bank, strobes each word out.
// Define SPECTRO_RX_SHADOW_EN to add a shadow bank committed on frame_done and read via rd_data.
//
// state | meaning
// IDLE  | waiting for frame_sync, sdata ignored
// RECV  | shifting bits of the current frame
module spectro_frame_rx #(
    parameter int WORD_W    = spectro_pkg::WORD_W,
    parameter int NUM_WORDS = spectro_pkg::NUM_WORDS
) (
    input logic                clk,
    input logic                reset,
    spectro_frame_rx_if.slave  bus
);
    import spectro_pkg::*;

    localparam logic [3:0] BIT_LAST  = 4'(WORD_W - 1);
    localparam logic [3:0] WORD_LAST = 4'(NUM_WORDS - 1);

    rx_state_t         state;
    rx_state_t         state_nx;
    logic [3:0]        bit_cnt;
    logic [3:0]        word_cnt;
    logic [WORD_W-1:0] word_par;

    logic shift_en;
    logic restart;
    logic word_fire;
    logic frame_fire;
    logic err_fire;

    logic [WORD_W-1:0] word_data;
    logic [3:0]        word_index;
    logic              word_valid;
    logic              frame_done;
    logic              frame_error;
    logic [WORD_W-1:0] live_bank [NUM_WORDS];

    spectro_sipo #(.WIDTH(WORD_W)) u_sipo (
        .clk      (clk),
        .clr      (reset),
        .shift_en (shift_en),
        .din      (bus.sdata),
        .par      (word_par)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.frame_sync) state_nx = RECV;
            RECV: if (!bus.frame_sync && bit_cnt == BIT_LAST && word_cnt == WORD_LAST)
                      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A sync in RECV restarts the frame and suppresses any word that would have completed.
    always_comb begin
        shift_en   = 1'b0;
        restart    = 1'b0;
        word_fire  = 1'b0;
        frame_fire = 1'b0;
        err_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.frame_sync) begin
                    shift_en = 1'b1;
                    restart  = 1'b1;
                end
            end
            RECV: begin
                shift_en = 1'b1;
                if (bus.frame_sync) begin
                    restart  = 1'b1;
                    err_fire = 1'b1;
                end else if (bit_cnt == BIT_LAST) begin
                    word_fire  = 1'b1;
                    frame_fire = (word_cnt == WORD_LAST);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt     <= '0;
            word_cnt    <= '0;
            word_data   <= '0;
            word_index  <= '0;
            word_valid  <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                live_bank[i] <= '0;
            end
        end else begin
            word_valid  <= word_fire;
            frame_done  <= frame_fire;
            frame_error <= err_fire;

            if (restart) begin
                bit_cnt  <= 4'd1;
                word_cnt <= '0;
            end else if (word_fire) begin
                bit_cnt  <= '0;
                word_cnt <= frame_fire ? 4'd0 : word_cnt + 4'd1;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (word_fire) begin
                word_data           <= word_par;
                word_index          <= word_cnt;
                live_bank[word_cnt] <= word_par;
            end
        end
    end

`ifdef SPECTRO_RX_SHADOW_EN
    logic [WORD_W-1:0] shadow_bank [NUM_WORDS];

    // The final word is taken straight from the shifter since the live bank gets it on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                shadow_bank[i] <= '0;
            end
        end else if (frame_fire) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                shadow_bank[i] <= (4'(i) == word_cnt) ? word_par : live_bank[i];
            end
        end
    end

    assign bus.rd_data = shadow_bank[bus.rd_addr];
`else
    assign bus.rd_data = live_bank[bus.rd_addr];
`endif

    assign bus.word_data   = word_data;
    assign bus.word_index  = word_index;
    assign bus.word_valid  = word_valid;
    assign bus.frame_done  = frame_done;
    assign bus.frame_error = frame_error;

endmodule

// File: tb/tb_spectro_frame_rx.sv
// Directed bench for spectro_frame_rx: scoreboard of expected word/error events plus a bank model.
module tb_spectro_frame_rx;
    import spectro_pkg::*;

    typedef struct {
        int          due;
        logic [11:0] data;
        logic [3:0]  idx;
        bit          done;
    } exp_t;

    typedef logic [11:0] frame_t [16];

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t        wq[$];
    int          eq[$];
    int          done_cyc[$];
    logic [11:0] live_m   [16];
    logic [11:0] shadow_m [16];
    logic [11:0] last_done_data;
    logic [3:0]  last_done_idx;

    spectro_frame_rx_if bus ();

    spectro_frame_rx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] rd_model(input int a);
`ifdef SPECTRO_RX_SHADOW_EN
        return shadow_m[a];
`else
        return live_m[a];
`endif
    endfunction

    // Per-cycle compare of the strobes and word payload against the scheduled expectations.
    always @(negedge clk) begin : cmp
        exp_t it;
        bit   ev;
        bit   ee;
        ev = 1'b0;
        ee = 1'b0;
        it.done = 1'b0;
        if (!reset) begin
            if (wq.size() > 0 && wq[0].due == cyc) begin
                it = wq.pop_front();
                ev = 1'b1;
                live_m[it.idx] = it.data;
                if (it.done) begin
                    for (int i = 0; i < 16; i++) shadow_m[i] = live_m[i];
                end
            end
            if (eq.size() > 0 && eq[0] == cyc) begin
                void'(eq.pop_front());
                ee = 1'b1;
            end
            chk("word_valid", 32'(bus.word_valid), 32'(ev));
            chk("frame_done", 32'(bus.frame_done), 32'(ev && it.done));
            chk("frame_error", 32'(bus.frame_error), 32'(ee));
            if (ev) begin
                chk("word_data", 32'(bus.word_data), 32'(it.data));
                chk("word_index", 32'(bus.word_index), 32'(it.idx));
            end
            if (bus.frame_done) begin
                done_cyc.push_back(cyc);
                last_done_data = bus.word_data;
                last_done_idx  = bus.word_index;
            end
        end
    end

    task automatic drive(input logic s, input logic b);
        @(negedge clk);
        bus.frame_sync = s;
        bus.sdata      = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [11:0] w, input logic [3:0] idx, input bit sync,
                             input bit done, input bit in_recv);
        for (int i = 11; i >= 0; i--) begin
            drive(sync && i == 11, w[i]);
            if (sync && i == 11 && in_recv) eq.push_back(cyc + 1);
            if (i == 0) wq.push_back('{cyc + 1, w, idx, done});
        end
    endtask

    task automatic send_partial(input logic [11:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) drive(1'b0, w[11 - i]);
    endtask

    task automatic send_frame(input frame_t f, input bit in_recv);
        for (int k = 0; k < 16; k++)
            send_word(f[k], 4'(k), k == 0, k == 15, k == 0 && in_recv);
    endtask

    task automatic check_rd(input int a);
        @(negedge clk);
        bus.rd_addr = 4'(a);
        #1;
        chk($sformatf("rd_data[%0d]", a), 32'(bus.rd_data), 32'(rd_model(a)));
    endtask

    task automatic check_rd_lit(input int a, input logic [11:0] v);
        @(negedge clk);
        bus.rd_addr = 4'(a);
        #1;
        chk($sformatf("rd_lit[%0d]", a), 32'(bus.rd_data), 32'(v));
    endtask

    task automatic sweep();
        for (int a = 0; a < 16; a++) check_rd(a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.frame_sync = 1'b0;
        bus.sdata = 1'b0;
        wq.delete();
        eq.delete();
        for (int i = 0; i < 16; i++) begin
            live_m[i]   = '0;
            shadow_m[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs();
        #1;
        chk("rst_word_data", 32'(bus.word_data), 32'h0);
        chk("rst_word_index", 32'(bus.word_index), 32'h0);
        chk("rst_word_valid", 32'(bus.word_valid), 32'h0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'h0);
        chk("rst_frame_error", 32'(bus.frame_error), 32'h0);
        for (int a = 0; a < 16; a++) check_rd_lit(a, 12'h000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t nom, f5, fc;
        int     nd;

        bus.sdata = 1'b0;
        bus.frame_sync = 1'b0;
        bus.rd_addr = 4'd0;

        do_reset();
        check_reset_outputs();
        idle(3);

        nom[IDX_RTC] = 12'hABC;
        for (int k = 1; k < 16; k++) nom[k] = 12'(k * 12'h101);
        send_frame(nom, 1'b0);
        idle(3);
        chk("nom_last_data", 32'(last_done_data), 32'hF0F);
        chk("nom_last_index", 32'(last_done_idx), 32'd15);
        check_rd_lit(0, 12'hABC);
        check_rd_lit(7, 12'h707);
        sweep();

        for (int k = 0; k < 16; k++) f5[k] = 12'h555;
        send_frame(nom, 1'b0);
        send_frame(f5, 1'b0);
        idle(3);
        chk("b2b_interval", 32'(done_cyc[done_cyc.size() - 1] - done_cyc[done_cyc.size() - 2]), 32'd192);
        for (int a = 0; a < 16; a++) check_rd_lit(a, 12'h555);

        nd = done_cyc.size();
        send_word(12'h321, IDX_RTC, 1'b1, 1'b0, 1'b0);
        send_word(12'h654, IDX_CH1, 1'b0, 1'b0, 1'b0);
        send_word(12'h987, IDX_CH2, 1'b0, 1'b0, 1'b0);
        send_partial(12'hFED, 5);
        for (int k = 0; k < 16; k++) fc[k] = 12'h800 | 12'(k * 3);
        fork
            send_frame(fc, 1'b1);
            begin
                repeat (40) @(negedge clk);
                sweep();
`ifdef SPECTRO_RX_SHADOW_EN
                check_rd_lit(4, 12'h555);
`else
                check_rd_lit(1, 12'h803);
`endif
            end
        join
        idle(3);
        chk("abort_done_count", 32'(done_cyc.size()), 32'(nd + 1));
        sweep();

        for (int k = 0; k < 8; k++) send_word(nom[k], 4'(k), k == 0, 1'b0, 1'b0);
        send_partial(nom[8], 5);
        do_reset();
        check_reset_outputs();
        idle(30);
        send_frame(nom, 1'b0);
        idle(3);
        sweep();

        nd = done_cyc.size();
        for (int i = 0; i < 500; i++) drive(1'b0, 1'($urandom_range(0, 1)));
        idle(3);
        chk("noise_done_count", 32'(done_cyc.size()), 32'(nd));

        chk("pending_words", 32'(wq.size()), 32'd0);
        chk("pending_errors", 32'(eq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
